// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: sigma constants, round count, FSM encoding, word helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package chacha20_pkg;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    localparam int NUM_HALF_ROUNDS = 20;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ROUND = 4'd1,
        ST_FINAL = 4'd2
    } fsm_state_t;

    // Working matrix: m[0] is word 0 of the ChaCha state.
    typedef logic [15:0][31:0] matrix_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Byte-reverse a word: big-endian byte stream <-> little-endian word value.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Initial matrix: constants, key words, counter, nonce words.
    function automatic matrix_t build_matrix(input logic [255:0] key,
                                             input logic [95:0]  nonce,
                                             input logic [31:0]  ctr);
        matrix_t m;
        m[0] = SIGMA0;
        m[1] = SIGMA1;
        m[2] = SIGMA2;
        m[3] = SIGMA3;
        for (int i = 0; i < 8; i++) begin
            m[4 + i] = bswap32(key[255 - 32 * i -: 32]);
        end
        m[12] = ctr;
        for (int i = 0; i < 3; i++) begin
            m[13 + i] = bswap32(nonce[95 - 32 * i -: 32]);
        end
        return m;
    endfunction

endpackage

// File: rtl/chacha20_quarter_round.sv
// ChaCha20 quarter-round on four 32-bit words.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module chacha20_quarter_round
    import chacha20_pkg::*;
(
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);

    logic [31:0] a1, b1, c1, d1;
    logic [31:0] a2, b2, c2, d2;

    assign a1 = a_in + b_in;
    assign d1 = rotl32(d_in ^ a1, 16);
    assign c1 = c_in + d1;
    assign b1 = rotl32(b_in ^ c1, 12);
    assign a2 = a1 + b1;
    assign d2 = rotl32(d1 ^ a2, 8);
    assign c2 = c1 + d2;
    assign b2 = rotl32(b1 ^ c2, 7);

    assign a_out = a2;
    assign b_out = b2;
    assign c_out = c2;
    assign d_out = d2;

endmodule

// File: rtl/chacha20.sv
// ChaCha20 block cipher core: one 64-byte block XORed with the keystream per request.
// Latency: start edge k, done pulses after edge k+21 (20 half-rounds + final add).
// Backpressure: start is ignored while busy; start held in the done cycle relaunches.
module chacha20
    import chacha20_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    input  logic [255:0] in_key,
    input  logic [95:0]  in_nonce,
    input  logic [31:0]  in_counter,
    input  logic [511:0] in_state,
    output logic [511:0] out_state,
    output logic [511:0] debug_s,
    output logic [511:0] debug_s_col_out,
    output logic [511:0] debug_s_round_result,
    output logic [3:0]   debug_fsm_state,
    output logic [4:0]   debug_round_count,
    output logic         debug_is_col_round
);

    fsm_state_t     state;
    fsm_state_t     state_nxt;
    logic           load;
    logic           step;
    logic           finish;

    logic [255:0]   key_q;
    logic [95:0]    nonce_q;
    logic [31:0]    counter_q;
    logic [511:0]   data_q;
    logic [4:0]     round_count;
    logic           done_q;
    logic [511:0]   out_q;

    matrix_t        s;
    matrix_t        init_q;
    matrix_t        col_out;
    matrix_t        diag_out;
    matrix_t        round_result;
    logic [511:0]   keystream;

    logic [31:0]    col_w  [16];
    logic [31:0]    diag_w [16];

    // Four column quarter-rounds and four diagonal quarter-rounds, both fed from s.
    for (genvar i = 0; i < 4; i++) begin : g_qr
        chacha20_quarter_round u_col (
            .a_in  (s[i]),
            .b_in  (s[4 + i]),
            .c_in  (s[8 + i]),
            .d_in  (s[12 + i]),
            .a_out (col_w[i]),
            .b_out (col_w[4 + i]),
            .c_out (col_w[8 + i]),
            .d_out (col_w[12 + i])
        );
        chacha20_quarter_round u_diag (
            .a_in  (s[i]),
            .b_in  (s[4 + ((i + 1) % 4)]),
            .c_in  (s[8 + ((i + 2) % 4)]),
            .d_in  (s[12 + ((i + 3) % 4)]),
            .a_out (diag_w[i]),
            .b_out (diag_w[4 + ((i + 1) % 4)]),
            .c_out (diag_w[8 + ((i + 2) % 4)]),
            .d_out (diag_w[12 + ((i + 3) % 4)])
        );
    end

    // Gather quarter-round outputs and pick the half-round for this cycle (even = column).
    always_comb begin
        col_out  = '0;
        diag_out = '0;
        for (int j = 0; j < 16; j++) begin
            col_out[j]  = col_w[j];
            diag_out[j] = diag_w[j];
        end
        round_result = round_count[0] ? diag_out : col_out;
    end

    assign init_q = build_matrix(key_q, nonce_q, counter_q);

    // Final feed-forward add, serialized word 0 first with each word little-endian.
    always_comb begin
        keystream = '0;
        for (int j = 0; j < 16; j++) begin
            keystream[511 - 32 * j -: 32] = bswap32(s[j] + init_q[j]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and datapath strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                step = 1'b1;
                if (round_count == 5'(NUM_HALF_ROUNDS - 1)) begin
                    state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                finish    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Input capture, half-round iteration and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            nonce_q     <= '0;
            counter_q   <= '0;
            data_q      <= '0;
            s           <= '0;
            round_count <= '0;
            done_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            done_q <= finish;
            if (load) begin
                key_q       <= in_key;
                nonce_q     <= in_nonce;
                counter_q   <= in_counter;
                data_q      <= in_state;
                s           <= build_matrix(in_key, in_nonce, in_counter);
                round_count <= '0;
            end else if (step) begin
                s <= round_result;
                if (round_count != 5'(NUM_HALF_ROUNDS - 1)) begin
                    round_count <= round_count + 5'd1;
                end
            end
            if (finish) begin
                out_q <= keystream ^ data_q;
            end
        end
    end

    assign busy                 = (state != ST_IDLE);
    assign done                 = done_q;
    assign out_state            = out_q;
    assign debug_s              = s;
    assign debug_s_col_out      = col_out;
    assign debug_s_round_result = round_result;
    assign debug_fsm_state      = state;
    assign debug_round_count    = round_count;
    assign debug_is_col_round   = (state == ST_ROUND) && !round_count[0];

endmodule

// File: tb/tb_chacha20.sv
// Scoreboard bench for chacha20: directed RFC vectors, round-trip, timing and reset abort.
// Latency: expects done one cycle after edge k+21 for a start at edge k.
// Backpressure: issues new blocks only when idle or in the done cycle.
module tb_chacha20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic         done;
    logic [255:0] in_key = '0;
    logic [95:0]  in_nonce = '0;
    logic [31:0]  in_counter = '0;
    logic [511:0] in_state = '0;
    logic [511:0] out_state;
    logic [511:0] debug_s;
    logic [511:0] debug_s_col_out;
    logic [511:0] debug_s_round_result;
    logic [3:0]   debug_fsm_state;
    logic [4:0]   debug_round_count;
    logic         debug_is_col_round;

    int n_tests = 0;
    int n_fail  = 0;

    logic [511:0] exp_q  [$];
    logic [511:0] mask_q [$];
    string        name_q [$];

    localparam logic [255:0] KEY     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [95:0]  NONCE_A = 96'h000000090000004a00000000;
    localparam logic [95:0]  NONCE_B = 96'h000000000000004a00000000;
    localparam logic [511:0] MASK128 = {128'hffffffffffffffffffffffffffffffff, 384'h0};
    localparam logic [511:0] MASK64  = {64'hffffffffffffffff, 448'h0};
    localparam logic [511:0] MASKALL = {512{1'b1}};
    localparam logic [511:0] EXP_A   = {128'h10f1e7e4d13b5915500fdd1fa32071c4, 384'h0};
    localparam logic [511:0] EXP_B   = {64'h224f51f3401bd9e1, 448'h0};
    localparam logic [511:0] PLAIN   = {16{32'h44434241}};
    localparam logic [511:0] EXP_P   = {64'h660c13b204589ba0, 448'h0};
    localparam logic [511:0] PATTERN = {8{64'hdeadbeef01234567}};

    chacha20 dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .busy                 (busy),
        .done                 (done),
        .in_key               (in_key),
        .in_nonce             (in_nonce),
        .in_counter           (in_counter),
        .in_state             (in_state),
        .out_state            (out_state),
        .debug_s              (debug_s),
        .debug_s_col_out      (debug_s_col_out),
        .debug_s_round_result (debug_s_round_result),
        .debug_fsm_state      (debug_fsm_state),
        .debug_round_count    (debug_round_count),
        .debug_is_col_round   (debug_is_col_round)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expectation; a zero mask means "drain only".
    always @(negedge clk) begin : monitor
        logic [511:0] e;
        logic [511:0] m;
        string        nm;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pending block");
            end else begin
                e  = exp_q.pop_front();
                m  = mask_q.pop_front();
                nm = name_q.pop_front();
                if (m != '0) chk(nm, out_state & m, e & m);
            end
        end
    end

    // Drive a request at a negedge; the following posedge is the start edge k.
    task automatic issue(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                         input logic [511:0] d, input logic [511:0] e, input logic [511:0] m,
                         input string nm, input bit push);
        chk32("idle_before_start", 32'(busy), 32'd0);
        in_key     = k;
        in_nonce   = n;
        in_counter = c;
        in_state   = d;
        start      = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            mask_q.push_back(m);
            name_q.push_back(nm);
        end
    endtask

    // Follow one block cycle by cycle; returns at the negedge of the done cycle.
    task automatic track(input bit pulse_mid, output logic [511:0] res);
        @(posedge clk);
        #1;
        start      = 1'b0;
        in_key     = ~in_key;
        in_nonce   = ~in_nonce;
        in_counter = ~in_counter;
        in_state   = ~in_state;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk32($sformatf("busy_round_%0d", i), 32'(busy), 32'd1);
            chk32($sformatf("done_low_round_%0d", i), 32'(done), 32'd0);
            chk32($sformatf("fsm_round_%0d", i), 32'(debug_fsm_state), 32'd1);
            chk32($sformatf("round_count_%0d", i), 32'(debug_round_count), 32'(i));
            chk32($sformatf("is_col_%0d", i), 32'(debug_is_col_round), 32'((i % 2) == 0));
            if (pulse_mid && i == 7) start = 1'b1;
            if (pulse_mid && i == 8) start = 1'b0;
        end
        @(negedge clk);
        chk32("fsm_final", 32'(debug_fsm_state), 32'd2);
        chk32("busy_final", 32'(busy), 32'd1);
        chk32("done_low_final", 32'(done), 32'd0);
        @(negedge clk);
        chk32("done_pulse", 32'(done), 32'd1);
        chk32("busy_low_at_done", 32'(busy), 32'd0);
        chk32("fsm_idle_at_done", 32'(debug_fsm_state), 32'd0);
        res = out_state;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_state"}, out_state, '0);
        chk({tag, "_debug_s"}, debug_s, '0);
        chk({tag, "_col_out"}, debug_s_col_out, '0);
        chk({tag, "_round_result"}, debug_s_round_result, '0);
        chk32({tag, "_ctrl"}, {20'h0, busy, done, debug_fsm_state, debug_round_count, debug_is_col_round}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [511:0] r;
        logic [511:0] ct;
        bit           hit;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // RFC 8439 block function vector; inputs scrambled after the start edge.
        issue(KEY, NONCE_A, 32'd1, '0, EXP_A, MASK128, "rfc_block_128", 1'b1);
        track(1'b0, r);
        @(negedge clk);
        chk32("done_one_cycle", 32'(done), 32'd0);

        // RFC 8439 encryption keystream, with a stray start pulse mid-block.
        issue(KEY, NONCE_B, 32'd1, '0, EXP_B, MASK64, "rfc_keystream_64", 1'b1);
        track(1'b1, r);
        @(negedge clk);
        chk32("mid_start_ignored_fsm", 32'(debug_fsm_state), 32'd0);
        chk32("mid_start_ignored_done", 32'(done), 32'd0);

        // Encrypt then decrypt back-to-back: second start held during the done cycle.
        issue(KEY, NONCE_B, 32'd1, PLAIN, EXP_P, MASK64, "encrypt_64", 1'b1);
        track(1'b0, ct);
        issue(KEY, NONCE_B, 32'd1, ct, PLAIN, MASKALL, "roundtrip_plain", 1'b1);
        track(1'b0, r);
        @(negedge clk);

        // Maximum counter, no increment: still a clean round trip.
        issue(KEY, NONCE_A, 32'hffffffff, PATTERN, '0, '0, "ctr_max_enc", 1'b1);
        track(1'b0, ct);
        @(negedge clk);
        issue(KEY, NONCE_A, 32'hffffffff, ct, PATTERN, MASKALL, "ctr_max_roundtrip", 1'b1);
        track(1'b0, r);
        @(negedge clk);

        // Abort a block at half-round 10 with reset; no done may follow.
        issue(KEY, NONCE_A, 32'd1, '0, '0, '0, "aborted", 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (debug_round_count == 5'd10) hit = 1'b1;
        end
        chk32("reach_round_10", 32'(hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk32("no_done_after_abort", 32'(done), 32'd0);

        issue(KEY, NONCE_A, 32'd1, '0, EXP_A, MASK128, "rfc_block_after_reset", 1'b1);
        track(1'b0, r);
        repeat (3) @(negedge clk);

        chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chacha20.md
CHACHA20 -- requirements
Module: chacha20

Interface
REQ-001 The block SHALL have no parameters; round count is fixed at 20.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
REQ-003 The remaining ports SHALL be exactly:
- start  input  1  request one block; sampled only in IDLE
- busy  output  1  high while a block is in progress
- done  output  1  one-cycle pulse when out_state is valid
- in_key  input  256  key; in_key[255:248] = key byte 0
- in_nonce  input  96  nonce; in_nonce[95:88] = nonce byte 0
- in_counter  input  32  block counter as integer
- in_state  input  512  data block; in_state[511:504] = data byte 0
- out_state  output  512  in_state XOR keystream
- debug_s  output  512  working matrix register
- debug_s_col_out  output  512  column-round result of debug_s (combinational)
- debug_s_round_result  output  512  value loaded into s at next edge (column or diagonal result)
- debug_fsm_state  output  4  current FSM state encoding
- debug_round_count  output  5  half-round index 0..19
- debug_is_col_round  output  1  high when current half-round is a column round

Function
REQ-004 The keystream SHALL be the RFC 8439 ChaCha20 block function: matrix = 4 sigma constants, 8 key words, counter, 3 nonce words; 20 rounds; final wordwise mod-2^32 add of initial matrix.
REQ-005 Key and nonce words SHALL be assembled little-endian from bytes (key word 0 = 0x03020100 for key bytes 00..03).
REQ-006 Keystream serialization SHALL be word 0..15, each word little-endian; keystream byte i aligns with bits [511-8i -: 8].
REQ-007 Quarter-round SHALL use 32-bit add mod 2^32, XOR, rotate-left by 16, 12, 8, 7.
REQ-008 FSM states SHALL be IDLE=4'd0, ROUND=4'd1, FINAL=4'd2.
REQ-009 In IDLE with start=1 at edge k: key, nonce, counter and in_state SHALL be latched, initial matrix loaded into s, round_count=0, state->ROUND, busy=1.
REQ-010 ROUND SHALL execute one half-round per cycle: even round_count = column round (4 parallel QRs), odd = diagonal round; 20 cycles total (edges k+1..k+20).
REQ-011 After half-round 19, state SHALL go to FINAL; at edge k+21 out_state <= (s + init) XOR latched in_state, done=1 for exactly one cycle, busy=0, state->IDLE.
REQ-012 start while busy SHALL be ignored; start held high in the cycle done is asserted SHALL launch a new block at the next edge.
REQ-013 out_state SHALL hold its value until the next block's FINAL; input changes after the start edge SHALL not affect the result.
REQ-014 Counter SHALL be used as given with no increment; 0xFFFFFFFF is valid.
REQ-015 Encryption and decryption SHALL be the same operation.

Reset
REQ-016 rst_n low SHALL asynchronously force state=IDLE, busy=0, done=0, out_state=0, s=0, round_count=0, latched inputs=0.
REQ-017 Reset mid-operation SHALL abort the block with no done pulse; first start after release SHALL behave as REQ-009.

Structure
REQ-018 Package chacha20_pkg SHALL hold sigma constants (0x61707865, 0x3320646e, 0x79622d32, 0x6b206574), NUM_HALF_ROUNDS=20, FSM state typedef, and rotl32 function.
REQ-019 Sub-module chacha20_quarter_round (combinational a,b,c,d in/out, 32-bit each) SHALL be instantiated 8 times (4 column, 4 diagonal).

Verification
REQ-020 Key 00..1f, nonce 000000090000004a00000000, counter 1, in_state 0 -> out_state[511:384]=128'h10f1e7e4d13b5915500fdd1fa32071c4.
REQ-021 Same key, nonce 000000000000004a00000000, counter 1, in_state 0 -> out_state[511:448]=64'h224f51f3401bd9e1.
REQ-022 Same inputs, in_state = repeating 0x44434241; feed out_state into second block run -> result equals original in_state exactly.
REQ-023 start at edge k -> busy high from k to k+21, done high for exactly one cycle after edge k+21, debug_round_count steps 0..19.
REQ-024 rst_n pulsed low at round 10 -> all outputs 0 immediately, no done; next start gives correct REQ-020 result.
REQ-025 start pulsed during ROUND -> ignored, result and timing unchanged.
